// File: rtl/ysyx_22041207_ifu.sv
// Instruction fetch unit: owns the PC, issues aligned 64-bit reads, extracts the
// 32-bit word and hands it to the decoder over a valid/ready handshake.
module ysyx_22041207_ifu #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [63:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [63:0] mem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  output logic        misalign
);

  localparam int unsigned XLEN  = 64;
  localparam int unsigned ILEN  = 32;
  localparam int unsigned STEP  = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_DRAIN = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t            state, state_next;
  logic [XLEN-1:0]   pc, pc_next;
  logic [ILEN-1:0]   inst_next;
  logic [XLEN-1:0]   inst_pc_next;
  logic              inst_valid_next;
  logic              resp_owed;
  logic              target_misaligned;

  // A response is still owed after this edge if one was accepted and has not yet arrived.
  assign resp_owed = ((state == S_WAIT)  && !mem_resp_valid) ||
                     ((state == S_REQ)   &&  mem_req_ready)  ||
                     ((state == S_DRAIN) && !mem_resp_valid);

  assign target_misaligned = (redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      pc            <= RESET_PC;
      inst          <= '0;
      inst_pc       <= '0;
      inst_valid    <= 1'b0;
      misalign      <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= {RESET_PC[XLEN-1:3], 3'b000};
    end else begin
      state         <= state_next;
      pc            <= pc_next;
      inst          <= inst_next;
      inst_pc       <= inst_pc_next;
      inst_valid    <= inst_valid_next;
      misalign      <= (state_next == S_ERR);
      mem_req_valid <= (state_next == S_REQ);
      mem_req_addr  <= {pc_next[XLEN-1:3], 3'b000};
    end
  end

  always_comb begin
    state_next      = state;
    pc_next         = pc;
    inst_next       = inst;
    inst_pc_next    = inst_pc;
    inst_valid_next = inst_valid;

    if (redirect_valid) begin
      // Redirect wins over every other event, including a same-cycle handshake.
      pc_next         = redirect_pc;
      inst_valid_next = 1'b0;
      if (resp_owed) begin
        state_next = S_DRAIN;
      end else if (target_misaligned) begin
        state_next = S_ERR;
      end else begin
        state_next = S_REQ;
      end
    end else begin
      case (state)
        S_IDLE: begin
          state_next = S_REQ;
        end
        S_REQ: begin
          if (mem_req_ready) begin
            state_next = S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_resp_valid) begin
            inst_next       = pc[2] ? mem_resp_data[63:32] : mem_resp_data[31:0];
            inst_pc_next    = pc;
            inst_valid_next = 1'b1;
            pc_next         = pc + XLEN'(STEP);
            state_next      = S_HOLD;
          end
        end
        S_HOLD: begin
          if (inst_ready) begin
            inst_valid_next = 1'b0;
            state_next      = S_REQ;
          end
        end
        S_DRAIN: begin
          // Orphaned response is dropped; a misaligned target is only honoured now.
          if (mem_resp_valid) begin
            state_next = (pc[1:0] != 2'b00) ? S_ERR : S_REQ;
          end
        end
        S_ERR: begin
          state_next = S_ERR;
        end
        default: begin
          state_next = S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22041207_ifu.sv
// Bench for ysyx_22041207_ifu: cycle vector table, directed corner sequences and a
// randomized run checked against an instruction-stream reference model.
module tb_ysyx_22041207_ifu;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        misalign;

  ysyx_22041207_ifu #(.RESET_PC(64'h8000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .misalign       (misalign)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  int n_checks = 0;
  int n_errors = 0;

  // Memory model state: one pending response with a countdown.
  logic        pend = 1'b0;
  logic [63:0] pend_addr = '0;
  int          pend_cnt = 0;
  int          lat = 0;

  function automatic logic [63:0] mem_rd(input logic [63:0] a);
    if (a == 64'h8000_0000) return 64'h00000013_00100093;
    return {(~a[31:0]) ^ 32'h1357_9BDF, a[31:0] ^ 32'h0F0F_F0F0};
  endfunction

  function automatic logic [31:0] exp_inst(input logic [63:0] p);
    logic [63:0] w;
    w = mem_rd({p[63:3], 3'b000});
    return p[2] ? w[63:32] : w[31:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 30) $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Advance one clock; memory accepts on the edge and answers after lat cycles.
  task automatic tick();
    logic        acc;
    logic [63:0] a;
    acc = (mem_req_valid === 1'b1) && mem_req_ready;
    a   = mem_req_addr;
    @(posedge clk);
    #1;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    if (acc) begin
      pend      = 1'b1;
      pend_addr = a;
      pend_cnt  = lat;
    end
    if (pend) begin
      if (pend_cnt == 0) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = mem_rd(pend_addr);
        pend           = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
  endtask

  task automatic wait_iv(input string name);
    int n;
    n = 0;
    while (inst_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    n_checks++;
    if (inst_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL %s: inst_valid=%b after 20 cycles, expected 1", name, inst_valid);
    end
  endtask

  typedef struct {
    logic        ird;
    logic        ereq;
    logic [63:0] eaddr;
    logic        eiv;
    logic [31:0] einst;
    logic [63:0] eipc;
    logic        emis;
  } vec_t;

  vec_t tbl[12];

  initial begin
    logic        seen;
    logic        p_iv, p_ird, p_rdv;
    logic [31:0] p_inst;
    logic [63:0] p_ipc, p_rdpc, ref_pc;
    int          consumed;

    tbl[0]  = '{1'b0, 1'b1, 64'h8000_0000, 1'b0, 32'h0,        64'h0,         1'b0};
    tbl[1]  = '{1'b0, 1'b0, 64'h8000_0000, 1'b0, 32'h0,        64'h0,         1'b0};
    tbl[2]  = '{1'b0, 1'b0, 64'h8000_0000, 1'b1, 32'h00100093, 64'h8000_0000, 1'b0};
    for (int i = 3; i <= 7; i++) tbl[i] = tbl[2];
    tbl[8]  = '{1'b1, 1'b1, 64'h8000_0000, 1'b0, 32'h00100093, 64'h8000_0000, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 64'h8000_0000, 1'b0, 32'h00100093, 64'h8000_0000, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 64'h8000_0008, 1'b1, 32'h00000013, 64'h8000_0004, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 64'h8000_0008, 1'b0, 32'h00000013, 64'h8000_0004, 1'b0};

    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_resp_data = '0; inst_ready = 1'b0;
    repeat (3) tick();
    chk("rst.req_valid", 64'(mem_req_valid), 64'd0);
    chk("rst.req_addr",  mem_req_addr, 64'h8000_0000);
    chk("rst.inst_valid", 64'(inst_valid), 64'd0);
    chk("rst.inst", 64'(inst), 64'd0);
    chk("rst.inst_pc", inst_pc, 64'd0);
    chk("rst.misalign", 64'(misalign), 64'd0);
    rst = 1'b0;

    // Zero-wait fetch, backpressure and second word of the same doubleword.
    for (int i = 0; i < 12; i++) begin
      inst_ready = tbl[i].ird;
      tick();
      chk($sformatf("vec%0d.req_valid", i), 64'(mem_req_valid), 64'(tbl[i].ereq));
      chk($sformatf("vec%0d.req_addr", i),  mem_req_addr, tbl[i].eaddr);
      chk($sformatf("vec%0d.inst_valid", i), 64'(inst_valid), 64'(tbl[i].eiv));
      chk($sformatf("vec%0d.inst", i), 64'(inst), 64'(tbl[i].einst));
      chk($sformatf("vec%0d.inst_pc", i), inst_pc, tbl[i].eipc);
      chk($sformatf("vec%0d.misalign", i), 64'(misalign), 64'(tbl[i].emis));
    end

    // Redirect in WAIT; orphan response 3 cycles later must be discarded.
    inst_ready = 1'b0; lat = 3;
    tick();
    chk("wait_redir.req_in_wait", 64'(mem_req_valid), 64'd0);
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0100;
    tick();
    redirect_valid = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 10 && mem_req_valid !== 1'b1; n++) begin
      seen = seen | inst_valid;
      tick();
    end
    chk("wait_redir.no_stale_inst", 64'(seen), 64'd0);
    chk("wait_redir.req_valid", 64'(mem_req_valid), 64'd1);
    chk("wait_redir.req_addr", mem_req_addr, 64'h8000_0100);
    lat = 0;
    wait_iv("wait_redir.fetch");
    chk("wait_redir.inst_pc", inst_pc, 64'h8000_0100);
    chk("wait_redir.inst", 64'(inst), 64'(exp_inst(64'h8000_0100)));

    // Redirect in HOLD with a same-cycle handshake: old instruction dropped.
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0024; inst_ready = 1'b1;
    tick();
    redirect_valid = 1'b0; inst_ready = 1'b0;
    chk("hold_redir.inst_valid", 64'(inst_valid), 64'd0);
    chk("hold_redir.req_valid", 64'(mem_req_valid), 64'd1);
    chk("hold_redir.req_addr", mem_req_addr, 64'h8000_0020);
    wait_iv("hold_redir.fetch");
    chk("hold_redir.inst_pc", inst_pc, 64'h8000_0024);
    chk("hold_redir.inst", 64'(inst), 64'(exp_inst(64'h8000_0024)));

    // Misaligned redirect halts fetch until an aligned redirect.
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0002;
    tick();
    redirect_valid = 1'b0;
    chk("err.misalign", 64'(misalign), 64'd1);
    chk("err.inst_valid", 64'(inst_valid), 64'd0);
    seen = 1'b0;
    for (int n = 0; n < 10; n++) begin
      seen = seen | mem_req_valid;
      tick();
    end
    chk("err.no_requests", 64'(seen), 64'd0);
    chk("err.misalign_held", 64'(misalign), 64'd1);
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0008;
    tick();
    redirect_valid = 1'b0;
    chk("err_exit.misalign", 64'(misalign), 64'd0);
    chk("err_exit.req_addr", mem_req_addr, 64'h8000_0008);
    wait_iv("err_exit.fetch");
    chk("err_exit.inst_pc", inst_pc, 64'h8000_0008);

    // Misaligned redirect while a response is owed: drain first, then halt.
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("drain_err.req_valid", 64'(mem_req_valid), 64'd1);
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0106; lat = 2;
    tick();
    redirect_valid = 1'b0;
    chk("drain_err.misalign_early", 64'(misalign), 64'd0);
    chk("drain_err.req_in_drain", 64'(mem_req_valid), 64'd0);
    for (int n = 0; n < 10 && misalign !== 1'b1; n++) tick();
    chk("drain_err.misalign", 64'(misalign), 64'd1);
    tick();
    chk("drain_err.no_req", 64'(mem_req_valid), 64'd0);
    lat = 0;
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0010;
    tick();
    redirect_valid = 1'b0;
    chk("drain_err.exit_addr", mem_req_addr, 64'h8000_0010);
    wait_iv("drain_err.fetch");
    chk("drain_err.inst_pc", inst_pc, 64'h8000_0010);

    // PC wrap at the top of the address space.
    redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    chk("wrap.req_addr_top", mem_req_addr, 64'hFFFF_FFFF_FFFF_FFF8);
    wait_iv("wrap.fetch_top");
    chk("wrap.inst_pc_top", inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap.inst_top", 64'(inst), 64'(exp_inst(64'hFFFF_FFFF_FFFF_FFFC)));
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("wrap.req_valid_zero", 64'(mem_req_valid), 64'd1);
    chk("wrap.req_addr_zero", mem_req_addr, 64'd0);
    wait_iv("wrap.fetch_zero");
    chk("wrap.inst_pc_zero", inst_pc, 64'd0);
    chk("wrap.inst_zero", 64'(inst), 64'(exp_inst(64'd0)));

    // Reset mid-transaction; the late response lands in IDLE/REQ and is ignored.
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0; lat = 2;
    tick();
    rst = 1'b1;
    tick();
    chk("midrst.req_valid", 64'(mem_req_valid), 64'd0);
    chk("midrst.req_addr", mem_req_addr, 64'h8000_0000);
    chk("midrst.inst_valid", 64'(inst_valid), 64'd0);
    chk("midrst.inst_pc", inst_pc, 64'd0);
    rst = 1'b0; lat = 0;
    wait_iv("midrst.fetch");
    chk("midrst.inst_pc_after", inst_pc, 64'h8000_0000);
    chk("midrst.inst_after", 64'(inst), 64'h0010_0093);

    // Random traffic against an in-order instruction stream model.
    ref_pc = 64'h8000_0000;
    consumed = 0;
    for (int c = 0; c < 3000; c++) begin
      inst_ready     = ($urandom % 3) != 0;
      mem_req_ready  = ($urandom % 2) != 0;
      redirect_valid = ($urandom % 25) == 0;
      redirect_pc    = 64'h8000_0000 + 64'($urandom % 64) * 64'd4;
      lat            = int'($urandom % 3);
      p_iv = inst_valid; p_ird = inst_ready; p_rdv = redirect_valid; p_rdpc = redirect_pc;
      p_inst = inst; p_ipc = inst_pc;
      tick();
      if (p_rdv) begin
        ref_pc = p_rdpc;
        chk("rand.redirect_drop", 64'(inst_valid), 64'd0);
      end else if (p_iv && p_ird) begin
        chk("rand.consume_pc", p_ipc, ref_pc);
        chk("rand.consume_inst", 64'(p_inst), 64'(exp_inst(ref_pc)));
        ref_pc = ref_pc + 64'd4;
        consumed++;
      end else if (p_iv) begin
        chk("rand.hold_valid", 64'(inst_valid), 64'd1);
        chk("rand.hold_inst", 64'(inst), 64'(p_inst));
        chk("rand.hold_pc", inst_pc, p_ipc);
      end
      if (mem_req_valid) begin
        chk("rand.req_addr", mem_req_addr, {ref_pc[63:3], 3'b000});
        chk("rand.one_outstanding", 64'(pend), 64'd0);
      end
      chk("rand.misalign", 64'(misalign), 64'd0);
    end
    redirect_valid = 1'b0;
    chk("rand.progress", 64'(consumed > 100), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ysyx_22041207_ifu.md
# ysyx_22041207_ifu

Instruction fetch unit for the NPC core: it owns the program counter, issues aligned 64-bit reads to instruction memory, and extracts the 32-bit instruction word. It presents that word to the decoder with a valid/ready handshake. Control-flow redirects (branch, jal, jalr, ecall trap, mret) arrive from the execute/CSR stage and flush any fetch in flight.

## Interface

Parameters:
- RESET_PC, 64'h80000000, first fetch address after reset.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  reset, synchronous and active-high.
- redirect_valid  in  1  replace the PC this cycle.
- redirect_pc  in  64  new PC when redirect_valid=1.
- mem_req_valid  out  1  read request valid; equals (state==REQ).
- mem_req_ready  in  1  memory accepts the request this cycle.
- mem_req_addr  out  64  {pc[63:3],3'b000}.
- mem_resp_valid  in  1  read data valid, one pulse per accepted request.
- mem_resp_data  in  64  read data.
- inst_valid  out  1  inst/inst_pc valid for the decoder.
- inst_ready  in  1  decoder consumes the instruction this cycle.
- inst  out  32  instruction word.
- inst_pc  out  64  PC of inst.
- misalign  out  1  fetch halted on a PC with pc[1:0]!=0.

## Operation

- Registers: pc[63:0], state, inst, inst_pc, inst_valid, misalign.
- Reset: state=IDLE, pc=RESET_PC, inst_valid=0, inst=0, inst_pc=0, misalign=0. mem_req_valid=0 and mem_req_addr={RESET_PC[63:3],000} during and after reset.
- States:
  - IDLE: go to REQ next cycle.
  - REQ: mem_req_valid=1. On mem_req_ready, go to WAIT.
  - WAIT: on mem_resp_valid, latch the instruction and go to HOLD.
    - inst = pc[2] ? data[63:32] : data[31:0].
    - inst_pc = pc, inst_valid = 1, pc = pc+4 (wraps modulo 2^64).
  - HOLD: inst_valid=1, outputs stable. On inst_ready, clear inst_valid and go to REQ.
  - DRAIN: an accepted request is orphaned. On mem_resp_valid, discard the data and go to REQ.
  - ERR: misalign=1, no requests. Leave only via redirect or rst.
- Redirect (redirect_valid=1) has priority over every other event in the same cycle:
  - pc = redirect_pc; inst_valid cleared (an unconsumed instruction is dropped, even if inst_ready=1 that cycle).
  - If redirect_pc[1:0]!=0: go to ERR and set misalign=1, except when a response is still owed (see next bullet).
  - Next state is DRAIN if a response is still owed: state WAIT with no mem_resp_valid this cycle, or state REQ with mem_req_ready=1 this cycle. A misaligned target is then checked after DRAIN, and ERR is entered instead of REQ.
  - Next state is DRAIN if already in DRAIN without mem_resp_valid this cycle.
  - Otherwise next state is REQ; misalign clears on an aligned redirect.
  - In WAIT with mem_resp_valid in the same cycle: the response is discarded and the next state is REQ.
- Only one request is outstanding at a time. The block never raises mem_req_valid while in WAIT or DRAIN.
- The block does not decode or interpret instructions.

## Timing

- Zero-wait memory (ready same cycle, response next cycle):
  - REQ at cycle t, WAIT at t+1 with the response, HOLD at t+2 with inst_valid=1.
  - With inst_ready held at 1, a new REQ occurs at t+3, giving 1 instruction per 3 cycles.
- Fetch latency: inst_valid rises the cycle after mem_resp_valid.
- Redirect latency:
  - Taking effect in HOLD or REQ (no handshake): mem_req_valid=1 with the new address in the next cycle.
  - Taking effect in WAIT: the new request follows the cycle after the orphan response.
- inst, inst_pc and inst_valid are held stable while inst_valid=1 and inst_ready=0, unless a redirect occurs.
- mem_req_addr is stable while mem_req_valid=1 and mem_req_ready=0, unless a redirect occurs.
- rst mid-transaction returns to IDLE. A memory response still owed arrives while in IDLE/REQ with no request outstanding and must be ignored; the memory model must tolerate this.

## Test plan

- Reset then zero-wait memory, RESET_PC=0x80000000:
  - Stimulus: word at 0x80000000 = 0x00000013_00100093.
  - Required: inst=0x00100093, inst_pc=0x80000000; then a second request to the same aligned address yields inst=0x00000013, inst_pc=0x80000004.
- Decoder backpressure: inst_ready=0 for 5 cycles -> inst/inst_pc/inst_valid unchanged, no mem_req_valid; inst_ready=1 -> REQ next cycle.
- Redirect in WAIT to 0x80000100 with the response arriving 3 cycles later -> that data is never presented; next mem_req_addr=0x80000100, inst_pc=0x80000100.
- Redirect in HOLD with inst_ready=1 in the same cycle, to 0x80000024 -> old instruction dropped; next request addr=0x80000020; inst taken from data[63:32], inst_pc=0x80000024.
- Redirect to 0x80000002 -> ERR, misalign=1, no requests for 10 cycles; redirect to 0x80000008 -> misalign=0, fetch resumes.
- pc=0xFFFFFFFF_FFFFFFFC fetch -> next pc wraps to 0x0, request addr=0x0.
